// File: rtl/oclib_lfsr_checker.sv
// Receive-side checker for an oclib_lfsr word stream: aligns a local LFSR, flags mismatches, counts errors.
// Optional first-error capture ports are built when OC_LFSR_CHECKER_FIRST_ERROR_EN is defined.
module oclib_lfsr_checker #(
  parameter Seed       = 1,
  parameter int OutWidth   = 32,
  parameter int LfsrWidth  = (OutWidth <= 9)  ? 9  :
                             (OutWidth <= 17) ? 17 :
                             (OutWidth <= 33) ? 33 :
                             (OutWidth <= 39) ? 39 : 65,
  parameter Poly       = (LfsrWidth == 9)  ? 65'h110 :
                         (LfsrWidth == 17) ? 65'h1_2000 :
                         (LfsrWidth == 33) ? 65'h1_0008_0000 :
                         (LfsrWidth == 39) ? 65'h44_0000_0000 :
                                             65'h1_0000_4000_0000_0000,
  parameter int LockCount  = 4,
  parameter int LossCount  = 8,
  parameter int CountWidth = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [OutWidth-1:0]   in_data,
  input  logic                  clear_errors,
  output logic                  locked,
  output logic                  error_pulse,
  output logic [CountWidth-1:0] error_count
`ifdef OC_LFSR_CHECKER_FIRST_ERROR_EN
  ,
  output logic [OutWidth-1:0]   first_error_data,
  output logic [OutWidth-1:0]   first_error_expected
`endif
);

  localparam logic [LfsrWidth-1:0] SeedVal  = LfsrWidth'(Seed);
  localparam logic [LfsrWidth-1:0] PolyMask = LfsrWidth'(Poly);

  localparam int MatchW = $clog2(LockCount + 1);
  localparam int MissW  = $clog2(LossCount + 1);
  localparam logic [MatchW-1:0]     LockTarget = MatchW'(LockCount);
  localparam logic [MissW-1:0]      LossTarget = MissW'(LossCount);
  localparam logic [MatchW-1:0]     MatchOne   = MatchW'(1);
  localparam logic [MissW-1:0]      MissOne    = MissW'(1);
  localparam logic [CountWidth-1:0] CountOne   = CountWidth'(1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // One word advance is LfsrWidth single-bit steps; unrolled it becomes pure XOR trees.
  function automatic logic [LfsrWidth-1:0] lfsr_advance(input logic [LfsrWidth-1:0] cur);
    logic [LfsrWidth-1:0] v;
    v = cur;
    for (int i = 0; i < LfsrWidth; i++) begin
      v = {v[LfsrWidth-2:0], ~^(v & PolyMask)};
    end
    return v;
  endfunction

  state_t                state_q, state_d;
  logic [LfsrWidth-1:0]  s_q, s_d, s_adv;
  logic [MatchW-1:0]     match_cnt_q, match_cnt_d;
  logic [MissW-1:0]      miss_cnt_q, miss_cnt_d;
  logic [CountWidth-1:0] error_count_d;
  logic [OutWidth-1:0]   expected_word;
  logic                  word_match;
  logic                  count_err;

  assign s_adv         = lfsr_advance(s_q);
  assign expected_word = s_q[OutWidth-1:0];
  assign word_match    = (in_data == expected_word);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    count_err   = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (word_match) begin
            s_d         = s_adv;
            match_cnt_d = MatchOne;
            miss_cnt_d  = '0;
            state_d     = (MatchOne == LockTarget) ? LOCKED : SYNC;
          end
        end
        SYNC: begin
          if (word_match) begin
            s_d         = s_adv;
            match_cnt_d = match_cnt_q + MatchOne;
            if (match_cnt_d == LockTarget) begin
              state_d    = LOCKED;
              miss_cnt_d = '0;
            end
          end else begin
            // The offending word is dropped, not retried against the seed.
            state_d     = HUNT;
            s_d         = SeedVal;
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          s_d = s_adv;
          if (word_match) begin
            miss_cnt_d = '0;
          end else begin
            count_err  = 1'b1;
            miss_cnt_d = miss_cnt_q + MissOne;
            if (miss_cnt_d == LossTarget) begin
              state_d     = HUNT;
              s_d         = SeedVal;
              miss_cnt_d  = '0;
              match_cnt_d = '0;
            end
          end
        end
        default: begin
          state_d = HUNT;
          s_d     = SeedVal;
        end
      endcase
    end

    // A clear coinciding with a counted mismatch leaves exactly that one error.
    error_count_d = clear_errors ? '0 : error_count;
    if (count_err && (error_count_d != '1)) begin
      error_count_d = error_count_d + CountOne;
    end
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= HUNT;
      s_q         <= SeedVal;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked      <= 1'b0;
      error_pulse <= 1'b0;
      error_count <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked      <= (state_d == LOCKED);
      error_pulse <= count_err;
      error_count <= error_count_d;
    end
  end

`ifdef OC_LFSR_CHECKER_FIRST_ERROR_EN
  logic first_captured;

  // Capture is rearmed by clear_errors; a mismatch in that same cycle is the new first error.
  always_ff @(posedge clock) begin
    if (reset) begin
      first_captured       <= 1'b0;
      first_error_data     <= '0;
      first_error_expected <= '0;
    end else if (count_err && (!first_captured || clear_errors)) begin
      first_captured       <= 1'b1;
      first_error_data     <= in_data;
      first_error_expected <= expected_word;
    end else if (clear_errors) begin
      first_captured       <= 1'b0;
      first_error_data     <= '0;
      first_error_expected <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_oclib_lfsr_checker.sv
// Directed bench for oclib_lfsr_checker at default parameters, with a bench-side generator model.
// Builds with or without OC_LFSR_CHECKER_FIRST_ERROR_EN.
module tb_oclib_lfsr_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        clear_errors = 1'b0;
  logic        locked;
  logic        error_pulse;
  logic [31:0] error_count;
`ifdef OC_LFSR_CHECKER_FIRST_ERROR_EN
  logic [31:0] first_error_data;
  logic [31:0] first_error_expected;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  oclib_lfsr_checker dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .clear_errors (clear_errors),
    .locked       (locked),
    .error_pulse  (error_pulse),
    .error_count  (error_count)
`ifdef OC_LFSR_CHECKER_FIRST_ERROR_EN
    ,
    .first_error_data     (first_error_data),
    .first_error_expected (first_error_expected)
`endif
  );

  // Generator model: 33-bit state, taps at bits 32 and 19, XNOR feedback, 33 shifts per word.
  logic [32:0] gen_s;

  function automatic logic [32:0] gen_step(input logic [32:0] v);
    logic [32:0] r;
    r = v;
    for (int i = 0; i < 33; i++) begin
      r = {r[31:0], ~(r[32] ^ r[19])};
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with a generator word (optionally corrupted); outputs sampled 1 time unit after the edge.
  task automatic send(input logic [31:0] corrupt, input logic clr = 1'b0);
    in_valid     = 1'b1;
    in_data      = gen_s[31:0] ^ corrupt;
    clear_errors = clr;
    gen_s        = gen_step(gen_s);
    @(posedge clock);
    #1;
    in_valid     = 1'b0;
    clear_errors = 1'b0;
  endtask

  task automatic idle(input logic [31:0] junk);
    in_valid = 1'b0;
    in_data  = junk;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    gen_s = 33'd1;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int sent;
    logic saw_pulse;

    // Reset values
    do_reset();
    check("first_word", {32'd0, gen_s[31:0]}, 64'h1);
    check("rst_locked", locked, 0);
    check("rst_pulse", error_pulse, 0);
    check("rst_count", error_count, 0);

    // Clean lock: locked rises in the cycle after word 4
    send(0); send(0); send(0);
    check("lock_after3", locked, 0);
    send(0);
    check("lock_after4", locked, 1);
    saw_pulse = 1'b0;
    for (int i = 4; i < 100; i++) begin
      send(0);
      saw_pulse |= error_pulse;
    end
    check("clean_pulse", saw_pulse, 0);
    check("clean_count", error_count, 0);
    check("clean_locked", locked, 1);

    // Idle cycle with garbage data changes nothing
    idle(32'hDEAD_BEEF);
    check("idle_pulse", error_pulse, 0);
    check("idle_locked", locked, 1);
    send(0);
    check("idle_resume", error_pulse, 0);

    // Single bit error while locked
    send(32'h1);
    check("single_pulse", error_pulse, 1);
    check("single_count", error_count, 1);
    check("single_locked", locked, 1);
`ifdef OC_LFSR_CHECKER_FIRST_ERROR_EN
    check("first_xor", first_error_data ^ first_error_expected, 1);
`endif
    send(0);
    check("single_pulse_off", error_pulse, 0);
    check("single_count_hold", error_count, 1);
    send(0); send(0);
    check("single_recover", error_pulse, 0);

    // Build error_count up to 5 with isolated errors, then clear in the same cycle as a mismatch
    for (int i = 0; i < 4; i++) begin
      send(32'h8000_0000);
      send(0);
    end
    check("count_five", error_count, 5);
    check("count_five_locked", locked, 1);
`ifdef OC_LFSR_CHECKER_FIRST_ERROR_EN
    check("first_held", first_error_data ^ first_error_expected, 1);
`endif
    send(32'h0000_0100, 1'b1);
    check("clear_collide", error_count, 1);
    check("clear_collide_pulse", error_pulse, 1);
`ifdef OC_LFSR_CHECKER_FIRST_ERROR_EN
    check("first_rearm", first_error_data ^ first_error_expected, 32'h100);
`endif
    send(0, 1'b1);
    check("clear_plain", error_count, 0);
    check("clear_keeps_lock", locked, 1);

    // Loss of lock after 8 consecutive mismatches
    for (int i = 0; i < 7; i++) send(32'hFFFF_FFFF);
    check("loss_7_locked", locked, 1);
    check("loss_7_count", error_count, 7);
    send(32'hFFFF_FFFF);
    check("loss_8_locked", locked, 0);
    check("loss_8_count", error_count, 8);
    check("loss_8_pulse", error_pulse, 1);
    for (int i = 0; i < 5; i++) send(0);
    check("hunt_stays", locked, 0);
    check("hunt_no_count", error_count, 8);
    check("hunt_no_pulse", error_pulse, 0);
    gen_s = 33'd1;
    send(0); send(0); send(0);
    check("relock_3", locked, 0);
    send(0);
    check("relock_4", locked, 1);

    // Reset overrides a valid word in the same cycle
    gen_s        = 33'd1;
    reset        = 1'b1;
    in_valid     = 1'b1;
    in_data      = 32'h1;
    clear_errors = 1'b0;
    @(posedge clock);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    check("rst_mid_locked", locked, 0);
    check("rst_mid_count", error_count, 0);

    // SYNC fallback: word 3 corrupted
    send(0); send(0);
    send(32'h0000_0010);
    check("sync_fall_locked", locked, 0);
    check("sync_fall_count", error_count, 0);
    for (int i = 0; i < 6; i++) send(0);
    check("sync_fall_stuck", locked, 0);
    check("sync_fall_count2", error_count, 0);
    gen_s = 33'd1;
    for (int i = 0; i < 4; i++) send(0);
    check("sync_relock", locked, 1);

    // Gaps: 30% valid duty after reset
    do_reset();
    sent = 0;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        send(0);
        sent++;
      end else begin
        idle($urandom);
      end
      check("gap_locked", locked, (sent >= 4) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) send(0);
    check("gap_final_locked", locked, 1);
    check("gap_count", error_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
